// File: rtl/serpent_cipher.sv
// Iterative Serpent core: the 256-bit key is re-expanded on every start,
// then one bitsliced round per clock over the 128-bit state.
module serpent_cipher (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_dir,
  input  logic [255:0] i_key,
  input  logic         i_new_block,
  input  logic [127:0] i_data,
  output logic         o_ready,
  output logic [127:0] o_output
);
  typedef enum logic [1:0] {
    IDLE,
    KEY,
    ROUND
  } state_t;

  localparam logic [31:0] PHI = 32'h9E3779B9;

  state_t       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         dir_q;
  logic [255:0] w_q, w_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] out_q;
  logic [127:0] sk_q [33];
  logic [127:0] sk_d;
  logic [4:0]   rc, rd;

  function automatic logic [31:0] rol(
    input logic [31:0] x,
    input int          n
  );
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ror(
    input logic [31:0] x,
    input int          n
  );
    return rol(x, 32 - n);
  endfunction

  // Nibble k of each constant is S(k)
  function automatic logic [3:0] sbox(
    input logic [2:0] n,
    input logic [3:0] x
  );
    logic [63:0] t;
    unique case (n)
      3'd0:    t = 64'hC90724DEB56A1F83;
      3'd1:    t = 64'h43D68EB1A50972CF;
      3'd2:    t = 64'h25B04E1DFAC39768;
      3'd3:    t = 64'hE57A421D369C8BF0;
      3'd4:    t = 64'hD7E9A4526B0C38F1;
      3'd5:    t = 64'h176D8E30C9A4B25F;
      3'd6:    t = 64'h0A3DF19EB6485C27;
      default: t = 64'h6539AC47B28E0FD1;
    endcase
    return t[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] isbox(
    input logic [2:0] n,
    input logic [3:0] y
  );
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      if (sbox(n, 4'(k)) == y) r = 4'(k);
    return r;
  endfunction

  function automatic logic [127:0] sl(
    input logic [2:0]   n,
    input logic         inv,
    input logic [127:0] x
  );
    logic [127:0] r;
    logic [3:0]   a, y;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      a = {x[96+b], x[64+b], x[32+b], x[b]};
      y = inv ? isbox(n, a) : sbox(n, a);
      r[b]    = y[0];
      r[32+b] = y[1];
      r[64+b] = y[2];
      r[96+b] = y[3];
    end
    return r;
  endfunction

  function automatic logic [127:0] lt(
    input logic [127:0] x
  );
    logic [31:0] a, b, c, d;
    {d, c, b, a} = x;
    a = rol(a, 13);
    c = rol(c, 3);
    b = b ^ a ^ c;
    d = d ^ c ^ (a << 3);
    b = rol(b, 1);
    d = rol(d, 7);
    a = a ^ b ^ d;
    c = c ^ d ^ (b << 7);
    a = rol(a, 5);
    c = rol(c, 22);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] ilt(
    input logic [127:0] x
  );
    logic [31:0] a, b, c, d;
    {d, c, b, a} = x;
    c = ror(c, 22);
    a = ror(a, 5);
    c = c ^ d ^ (b << 7);
    a = a ^ b ^ d;
    d = ror(d, 7);
    b = ror(b, 1);
    d = d ^ c ^ (a << 3);
    b = b ^ a ^ c;
    c = ror(c, 3);
    a = ror(a, 13);
    return {d, c, b, a};
  endfunction

  // Slides the 8-word prekey window forward by four chained words
  function automatic logic [255:0] kexp(
    input logic [255:0] w,
    input logic [5:0]   j
  );
    logic [31:0] t [12];
    for (int k = 0; k < 8; k++)
      t[k] = w[32*k +: 32];
    for (int k = 0; k < 4; k++)
      t[8+k] = rol(t[k] ^ t[k+3] ^ t[k+5] ^ t[k+7]
                   ^ PHI ^ {24'd0, j, 2'(k)}, 11);
    return {t[11], t[10], t[9], t[8],
            t[7], t[6], t[5], t[4]};
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ROUND && cnt_q == 6'd31)
        out_q <= blk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_new_block) state_d = KEY;
      end
      KEY: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd32) begin
          cnt_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready  = (state_q == IDLE);
    o_output = out_q;
  end

  assign rc = cnt_q[4:0];
  assign rd = ~rc;

  always_comb begin
    w_d   = kexp(w_q, cnt_q);
    sk_d  = sl(3'd3 - cnt_q[2:0], 1'b0, w_d[255:128]);
    blk_d = blk_q;
    unique case (1'b1)
      !dir_q && rc != 5'd31:
        blk_d = lt(sl(rc[2:0], 1'b0, blk_q ^ sk_q[cnt_q]));
      !dir_q && rc == 5'd31:
        blk_d = sl(3'd7, 1'b0, blk_q ^ sk_q[31]) ^ sk_q[32];
      dir_q && rc == 5'd0:
        blk_d = sl(3'd7, 1'b1, blk_q ^ sk_q[32]) ^ sk_q[31];
      default:
        blk_d = sl(rd[2:0], 1'b1, ilt(blk_q)) ^ sk_q[{1'b0, rd}];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (state_q == IDLE && i_new_block) begin
      dir_q <= i_dir;
      w_q   <= i_key;
      blk_q <= i_data;
    end
    if (state_q == KEY) begin
      w_q          <= w_d;
      sk_q[cnt_q]  <= sk_d;
    end
    if (state_q == ROUND)
      blk_q <= blk_d;
  end
endmodule

// File: tb/tb_serpent_cipher.sv
// Directed bench for serpent_cipher: timing, encrypt/decrypt,
// busy-start rejection, mid-run reset and back-to-back starts.
module tb_serpent_cipher;
  logic         clk;
  logic         rstn;
  logic         dir;
  logic [255:0] key;
  logic         newb;
  logic [127:0] data;
  logic         rdy;
  logic [127:0] dout;

  int nvec;
  int nerr;

  localparam logic [255:0] K1 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic [127:0] ct [10];

  int sb [8][16] = '{
    '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
    '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
    '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
    '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
    '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
    '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
    '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
    '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
  };

  serpent_cipher dut (
    .i_clk       (clk),
    .i_resetn    (rstn),
    .i_dir       (dir),
    .i_key       (key),
    .i_new_block (newb),
    .i_data      (data),
    .o_ready     (rdy),
    .o_output    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] m_rol(logic [31:0] x, int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] m_sub(int n, logic [127:0] x);
    logic [127:0] y;
    int v;
    y = '0;
    for (int b = 0; b < 32; b++) begin
      v = int'(x[b]) + 2 * int'(x[32+b])
        + 4 * int'(x[64+b]) + 8 * int'(x[96+b]);
      v = sb[n][v];
      y[b]    = v[0];
      y[32+b] = v[1];
      y[64+b] = v[2];
      y[96+b] = v[3];
    end
    return y;
  endfunction

  function automatic logic [127:0] m_lt(logic [127:0] in);
    logic [31:0] x [4];
    for (int i = 0; i < 4; i++) x[i] = in[32*i +: 32];
    x[0] = m_rol(x[0], 13);
    x[2] = m_rol(x[2], 3);
    x[1] = x[1] ^ x[0] ^ x[2];
    x[3] = x[3] ^ x[2] ^ (x[0] << 3);
    x[1] = m_rol(x[1], 1);
    x[3] = m_rol(x[3], 7);
    x[0] = x[0] ^ x[1] ^ x[3];
    x[2] = x[2] ^ x[3] ^ (x[1] << 7);
    x[0] = m_rol(x[0], 5);
    x[2] = m_rol(x[2], 22);
    return {x[3], x[2], x[1], x[0]};
  endfunction

  function automatic logic [127:0] m_enc(
    logic [255:0] k, logic [127:0] pt
  );
    logic [31:0]  w [140];
    logic [127:0] sk [33];
    logic [127:0] b;
    for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
    for (int i = 0; i < 132; i++)
      w[i+8] = m_rol(w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7]
                     ^ 32'h9E3779B9 ^ 32'(i), 11);
    for (int j = 0; j < 33; j++)
      sk[j] = m_sub((35 - j) % 8, {w[4*j+11], w[4*j+10],
                                    w[4*j+9], w[4*j+8]});
    b = pt;
    for (int r = 0; r < 32; r++) begin
      b = m_sub(r % 8, b ^ sk[r]);
      if (r < 31) b = m_lt(b);
      else b = b ^ sk[32];
    end
    return b;
  endfunction

  task automatic start_op(
    input logic d, input logic [255:0] k, input logic [127:0] x
  );
    @(negedge clk);
    dir  = d;
    key  = k;
    data = x;
    newb = 1'b1;
    @(posedge clk);
    #1;
    newb = 1'b0;
  endtask

  task automatic wait_ready(
    input int lat0, output int lat, output bit stable
  );
    logic [127:0] held;
    held   = dout;
    lat    = lat0;
    stable = 1'b1;
    while (!rdy && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (!rdy && dout !== held) stable = 1'b0;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    newb = 1'b1;
    data = 128'h1;
    repeat (20) @(posedge clk);
    #1;
    nvec++;
    if (rdy !== 1'b1) begin
      nerr++;
      $display("FAIL reset_ready: got %b expected 1", rdy);
    end
    nvec++;
    if (dout !== 128'h0) begin
      nerr++;
      $display("FAIL reset_out: got %h expected 0", dout);
    end
    @(negedge clk);
    newb = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if (rdy !== 1'b1) begin
      nerr++;
      $display("FAIL reset_idle: got %b expected 1", rdy);
    end
  endtask

  task automatic test_encrypt;
    int lat;
    bit st;
    logic [127:0] exp;
    for (int i = 0; i < 10; i++) begin
      exp = m_enc(K1, 128'(i));
      start_op(1'b0, K1, 128'(i));
      nvec++;
      if (rdy !== 1'b0) begin
        nerr++;
        $display("FAIL enc_busy[%0d]: got %b expected 0", i, rdy);
      end
      wait_ready(0, lat, st);
      nvec++;
      if (lat !== 65) begin
        nerr++;
        $display("FAIL enc_lat[%0d]: got %0d expected 65", i, lat);
      end
      nvec++;
      if (!st) begin
        nerr++;
        $display("FAIL enc_hold[%0d]: output moved while busy", i);
      end
      nvec++;
      if (dout !== exp) begin
        nerr++;
        $display("FAIL enc_val[%0d]: got %h expected %h", i, dout, exp);
      end
      ct[i] = exp;
    end
  endtask

  task automatic test_decrypt;
    int lat;
    bit st;
    for (int i = 0; i < 10; i++) begin
      start_op(1'b1, K1, ct[i]);
      wait_ready(0, lat, st);
      nvec++;
      if (lat !== 65) begin
        nerr++;
        $display("FAIL dec_lat[%0d]: got %0d expected 65", i, lat);
      end
      nvec++;
      if (dout !== 128'(i)) begin
        nerr++;
        $display("FAIL dec_val[%0d]: got %h expected %h",
                 i, dout, 128'(i));
      end
    end
  endtask

  task automatic test_busy_start;
    int lat;
    bit st;
    logic [127:0] exp;
    exp = m_enc(K1, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    start_op(1'b0, K1, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    repeat (9) @(posedge clk);
    @(negedge clk);
    newb = 1'b1;
    dir  = 1'b1;
    key  = ~K1;
    data = 128'h5555;
    @(posedge clk);
    #1;
    newb = 1'b0;
    wait_ready(10, lat, st);
    nvec++;
    if (lat !== 65) begin
      nerr++;
      $display("FAIL busy_lat: got %0d expected 65", lat);
    end
    nvec++;
    if (dout !== exp) begin
      nerr++;
      $display("FAIL busy_val: got %h expected %h", dout, exp);
    end
    @(posedge clk);
    #1;
    nvec++;
    if (rdy !== 1'b1) begin
      nerr++;
      $display("FAIL busy_norestart: got %b expected 1", rdy);
    end
  endtask

  task automatic test_mid_reset;
    int lat;
    bit st;
    start_op(1'b0, K1, 128'h77);
    repeat (54) @(posedge clk);
    #1;
    nvec++;
    if (rdy !== 1'b0) begin
      nerr++;
      $display("FAIL midrst_busy: got %b expected 0", rdy);
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    nvec++;
    if (rdy !== 1'b1) begin
      nerr++;
      $display("FAIL midrst_ready: got %b expected 1", rdy);
    end
    nvec++;
    if (dout !== 128'h0) begin
      nerr++;
      $display("FAIL midrst_out: got %h expected 0", dout);
    end
    @(negedge clk);
    rstn = 1'b1;
    start_op(1'b1, K1, ct[3]);
    wait_ready(0, lat, st);
    nvec++;
    if (lat !== 65) begin
      nerr++;
      $display("FAIL midrst_lat: got %0d expected 65", lat);
    end
    nvec++;
    if (dout !== 128'h3) begin
      nerr++;
      $display("FAIL midrst_val: got %h expected 3", dout);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit st;
    logic [127:0] exp;
    logic [127:0] prev;
    exp = m_enc(256'h0, {128{1'b1}});
    @(negedge clk);
    dir  = 1'b0;
    key  = 256'h0;
    data = {128{1'b1}};
    newb = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (rdy !== 1'b0) begin
        nerr++;
        $display("FAIL b2b_start[%0d]: got %b expected 0", k, rdy);
      end
      wait_ready(0, lat, st);
      if (k == 2) newb = 1'b0;
      nvec++;
      if (lat !== 65) begin
        nerr++;
        $display("FAIL b2b_lat[%0d]: got %0d expected 65", k, lat);
      end
      nvec++;
      if (dout !== exp) begin
        nerr++;
        $display("FAIL b2b_val[%0d]: got %h expected %h", k, dout, exp);
      end
      if (k > 0) begin
        nvec++;
        if (dout !== prev) begin
          nerr++;
          $display("FAIL b2b_same[%0d]: got %h expected %h",
                   k, dout, prev);
        end
      end
      prev = dout;
      @(posedge clk);
      #1;
    end
    nvec++;
    if (rdy !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_stop: got %b expected 1", rdy);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rstn = 1'b0;
    dir  = 1'b0;
    key  = '0;
    newb = 1'b0;
    data = '0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_busy_start();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
